bob_except_ctrl: RTL and testbench

//  Sequencer for the 48-entry x 10-slot exception bundle buffer (bob_except).
//  - Allocates bundle entries at the tail; drives the writeInit port.
//  - Tracks per-entry completion reported by the execution units.
//  - Drives read_step/read_addr to present the head bundle to retire, in order.
//  - Handles the retire handshake and pipeline flush.

---
 rtl/bob_pkg.sv | 14 +
 rtl/bob_inflight_chk.sv | 14 +
 rtl/bob_except_ctrl.sv | 127 ++++++++++++
 tb/tb_bob_except_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bob_pkg.sv
// bob_pkg: shared depth/width constants, FSM state type and the mod-48 pointer increment
// for the bob_except sequencer.
package bob_pkg;
    localparam int BOB_DEPTH = 48;
    localparam int BOB_PTR_W = 6;
    localparam logic [BOB_PTR_W-1:0] BOB_LAST = BOB_PTR_W'(BOB_DEPTH - 1);
    localparam logic [BOB_PTR_W-1:0] BOB_CNT_FULL = BOB_PTR_W'(BOB_DEPTH);

    typedef enum logic [1:0] {IDLE, VLD, FLUSH} bob_state_t;

    function automatic logic [BOB_PTR_W-1:0] bob_ptr_inc(input logic [BOB_PTR_W-1:0] p);
        return (p == BOB_LAST) ? '0 : p + 1'b1;
    endfunction
endpackage

// File: rtl/bob_inflight_chk.sv
// bob_inflight_chk: is entry a_i inside the occupied window [head,tail), with wrap;
// head==tail means empty unless full_i is set.
module bob_inflight_chk
    import bob_pkg::*;
(
    input  logic [BOB_PTR_W-1:0] a_i,
    input  logic [BOB_PTR_W-1:0] head_i,
    input  logic [BOB_PTR_W-1:0] tail_i,
    input  logic                 full_i,
    output logic                 hit_o
);
    assign hit_o = (a_i <= BOB_LAST) & (full_i | ((head_i <= tail_i) ?
                   (a_i >= head_i && a_i < tail_i) : (a_i >= head_i || a_i < tail_i)));
endmodule

// File: rtl/bob_except_ctrl.sv
// bob_except_ctrl: allocate/complete/retire sequencer for the 48-entry bob_except buffer.
// Define BOB_EXCEPT_CTRL_STATS_EN to add saturating retire/stall/flush counters.
module bob_except_ctrl
    import bob_pkg::*;
#(
    parameter int NDONE = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_req,
    output logic                       alloc_gnt,
    output logic                       writeInit_wen,
    output logic [BOB_PTR_W-1:0]       writeInit_addr,
    input  logic [NDONE-1:0]           done_wen,
    input  logic [NDONE*BOB_PTR_W-1:0] done_addr,
    output logic                       read_step,
    output logic [BOB_PTR_W-1:0]       read_addr,
    output logic                       retire_valid,
    output logic [BOB_PTR_W-1:0]       retire_addr,
    input  logic                       retire_ack,
    input  logic                       flush_req,
    output logic [BOB_PTR_W-1:0]       count,
    output logic                       full,
    output logic                       empty
`ifdef BOB_EXCEPT_CTRL_STATS_EN
    ,
    output logic [31:0]                stat_retired,
    output logic [31:0]                stat_full_stall,
    output logic [15:0]                stat_flush
`endif
);
    localparam int PW = BOB_PTR_W;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d, head_nxt;
    logic [BOB_DEPTH-1:0] done_q, done_d;
    bob_state_t state_q, state_d;
    logic [NDONE-1:0] infl;
    logic fire;

    assign full           = count_q == BOB_CNT_FULL;
    assign empty          = count_q == '0;
    assign count          = count_q;
    assign alloc_gnt      = alloc_req & ~full & ~flush_req & (state_q != FLUSH);
    assign writeInit_wen  = alloc_gnt;
    assign writeInit_addr = tail_q;
    assign retire_valid   = state_q == VLD;
    assign retire_addr    = head_q;
    assign fire           = retire_valid & retire_ack & ~flush_req;
    assign head_nxt       = bob_ptr_inc(head_q);

    for (genvar i = 0; i < NDONE; i++) begin : g_chk
        bob_inflight_chk u_chk (
            .a_i    (done_addr[i*PW +: PW]),
            .head_i (head_q),
            .tail_i (tail_q),
            .full_i (full),
            .hit_o  (infl[i])
        );
    end

    // Clear-on-alloc is applied last so it wins over a completion in the same cycle.
    always_comb begin
        head_d  = fire ? head_nxt : head_q;
        tail_d  = flush_req ? head_q : alloc_gnt ? bob_ptr_inc(tail_q) : tail_q;
        count_d = flush_req ? '0 : count_q + PW'(alloc_gnt) - PW'(fire);
        done_d  = done_q;
        for (int i = 0; i < NDONE; i++)
            if (done_wen[i] && infl[i]) done_d[done_addr[i*PW +: PW]] = 1'b1;
        if (fire) done_d[head_q] = 1'b0;
        if (alloc_gnt) done_d[tail_q] = 1'b0;
        if (flush_req) done_d = '0;
    end

    // On a retire the next head is prefetched immediately if already complete.
    always_comb begin
        state_d   = state_q;
        read_step = 1'b0;
        read_addr = head_q;
        if (flush_req) state_d = FLUSH;
        else if (state_q == FLUSH) state_d = IDLE;
        else if (state_q == IDLE && !empty && done_q[head_q]) begin
            read_step = 1'b1;
            state_d   = VLD;
        end else if (fire) begin
            read_addr = head_nxt;
            read_step = (count_q > PW'(1)) & done_q[head_nxt];
            state_d   = read_step ? VLD : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
            state_q <= IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

`ifdef BOB_EXCEPT_CTRL_STATS_EN
    logic [31:0] stat_retired_q, stat_full_stall_q;
    logic [15:0] stat_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_retired_q    <= '0;
            stat_full_stall_q <= '0;
            stat_flush_q      <= '0;
        end else begin
            if (fire && ~&stat_retired_q) stat_retired_q <= stat_retired_q + 1'b1;
            if (alloc_req && full && ~&stat_full_stall_q) stat_full_stall_q <= stat_full_stall_q + 1'b1;
            if (flush_req && ~&stat_flush_q) stat_flush_q <= stat_flush_q + 1'b1;
        end
    end

    assign stat_retired    = stat_retired_q;
    assign stat_full_stall = stat_full_stall_q;
    assign stat_flush      = stat_flush_q;
`endif
endmodule

// File: tb/tb_bob_except_ctrl.sv
// tb_bob_except_ctrl: scenario tasks with an in-order retire scoreboard for bob_except_ctrl.
module tb_bob_except_ctrl;
    logic        clk = 0, rst = 1;
    logic        alloc_req = 0, retire_ack = 0, flush_req = 0;
    logic [6:0]  done_wen = '0;
    logic [41:0] done_addr = '0;
    logic        alloc_gnt, writeInit_wen, read_step, retire_valid, full, empty;
    logic [5:0]  writeInit_addr, read_addr, retire_addr, count;

    int total = 0, bad = 0;
    logic [5:0] exp_q[$];
    logic [5:0] mh, mt;

    bob_except_ctrl dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
        .writeInit_wen(writeInit_wen), .writeInit_addr(writeInit_addr),
        .done_wen(done_wen), .done_addr(done_addr), .read_step(read_step),
        .read_addr(read_addr), .retire_valid(retire_valid), .retire_addr(retire_addr),
        .retire_ack(retire_ack), .flush_req(flush_req), .count(count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] inc(input logic [5:0] p);
        return (p == 6'd47) ? 6'd0 : p + 6'd1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        tick;
        rst = 0;
        mh = 0;
        mt = 0;
        exp_q.delete();
    endtask

    task automatic set_done(input int p, input logic [5:0] a);
        done_wen[p] = 1'b1;
        done_addr[p*6 +: 6] = a;
    endtask

    task automatic wait_vld(output bit ok);
        int w = 0;
        while (!retire_valid && w < 30) begin
            tick;
            w++;
        end
        ok = retire_valid;
    endtask

    // Scoreboard consumer: holds ack and pops the expected entry for each retire.
    task automatic drain(input int n);
        bit ok;
        logic [5:0] e;
        retire_ack = 1;
        for (int k = 0; k < n; k++) begin
            wait_vld(ok);
            total++;
            if (!ok || exp_q.size() == 0) begin
                bad++;
                $display("FAIL drain_timeout k=%0d valid=%0b queued=%0d", k, retire_valid, exp_q.size());
                break;
            end
            e = exp_q.pop_front();
            if (retire_addr !== e) begin
                bad++;
                $display("FAIL drain_order got=%0d exp=%0d", retire_addr, e);
            end
            mh = inc(mh);
            tick;
        end
        retire_ack = 0;
    endtask

    task automatic alloc_n(input int n, input string nm);
        alloc_req = 1;
        for (int k = 0; k < n; k++) begin
            #1;
            total++;
            if (alloc_gnt !== 1'b1 || writeInit_addr !== mt) begin
                bad++;
                $display("FAIL %s_alloc k=%0d gnt=%0b addr=%0d exp_addr=%0d", nm, k, alloc_gnt, writeInit_addr, mt);
            end
            tick;
            exp_q.push_back(mt);
            mt = inc(mt);
        end
        alloc_req = 0;
    endtask

    task automatic test_reset;
        bit ok;
        do_reset;
        total++;
        if ({empty, full, count, retire_valid, read_step, alloc_gnt, writeInit_addr} !== {1'b1, 1'b0, 6'd0, 3'b000, 6'd0}) begin
            bad++;
            $display("FAIL reset_state got e=%0b f=%0b c=%0d v=%0b rs=%0b g=%0b wa=%0d exp e=1 rest 0",
                     empty, full, count, retire_valid, read_step, alloc_gnt, writeInit_addr);
        end
        alloc_n(1, "rst");
        set_done(0, 6'd0);
        tick;
        done_wen = '0;
        wait_vld(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reset_pre_vld valid=%0b exp=1", retire_valid);
        end
        rst = 1;
        #1;
        total++;
        if ({retire_valid, read_step, count, empty} !== {2'b00, 6'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid_vld got v=%0b rs=%0b c=%0d e=%0b exp v=0 rs=0 c=0 e=1",
                     retire_valid, read_step, count, empty);
        end
        tick;
        rst = 0;
        mh = 0;
        mt = 0;
        exp_q.delete();
    endtask

    task automatic test_in_order;
        logic [5:0] e;
        alloc_n(3, "ord");
        set_done(0, 6'd2);
        tick;
        done_wen = '0;
        set_done(1, 6'd0);
        tick;
        done_wen = '0;
        total++;
        if (read_step !== 1'b1 || read_addr !== 6'd0 || retire_valid !== 1'b0) begin
            bad++;
            $display("FAIL ord_latency_n1 rs=%0b ra=%0d v=%0b exp rs=1 ra=0 v=0", read_step, read_addr, retire_valid);
        end
        set_done(2, 6'd1);
        tick;
        done_wen = '0;
        retire_ack = 1;
        for (int r = 0; r < 3; r++) begin
            e = exp_q.pop_front();
            total++;
            if (retire_valid !== 1'b1 || retire_addr !== e) begin
                bad++;
                $display("FAIL ord_b2b r=%0d v=%0b addr=%0d exp v=1 addr=%0d", r, retire_valid, retire_addr, e);
            end
            mh = inc(mh);
            tick;
        end
        retire_ack = 0;
        total++;
        if (retire_valid !== 1'b0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL ord_end v=%0b e=%0b exp v=0 e=1", retire_valid, empty);
        end
    endtask

    task automatic test_full;
        bit ok;
        alloc_n(48, "full");
        total++;
        if (count !== 6'd48 || full !== 1'b1 || writeInit_addr !== mh) begin
            bad++;
            $display("FAIL full_state c=%0d f=%0b wa=%0d exp c=48 f=1 wa=%0d", count, full, writeInit_addr, mh);
        end
        alloc_req = 1;
        #1;
        total++;
        if (alloc_gnt !== 1'b0) begin
            bad++;
            $display("FAIL full_49th gnt=%0b exp=0", alloc_gnt);
        end
        alloc_req = 0;
        set_done(4, mh);
        tick;
        done_wen = '0;
        wait_vld(ok);
        alloc_req = 1;
        retire_ack = 1;
        #1;
        total++;
        if (!ok || alloc_gnt !== 1'b0 || retire_addr !== exp_q[0]) begin
            bad++;
            $display("FAIL full_ack_gnt v=%0b gnt=%0b ra=%0d exp v=1 gnt=0 ra=%0d", retire_valid, alloc_gnt, retire_addr, exp_q[0]);
        end
        tick;
        retire_ack = 0;
        void'(exp_q.pop_front());
        mh = inc(mh);
        total++;
        if (count !== 6'd47 || full !== 1'b0 || alloc_gnt !== 1'b1 || writeInit_addr !== mt) begin
            bad++;
            $display("FAIL full_after_ret c=%0d f=%0b gnt=%0b wa=%0d exp c=47 f=0 gnt=1 wa=%0d",
                     count, full, alloc_gnt, writeInit_addr, mt);
        end
        tick;
        alloc_req = 0;
        flush_req = 1;
        tick;
        flush_req = 0;
        tick;
        mt = mh;
        exp_q.delete();
        total++;
        if (count !== 6'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL full_flush c=%0d e=%0b exp c=0 e=1", count, empty);
        end
    endtask

    task automatic test_flush;
        bit ok;
        logic [5:0] oh;
        alloc_n(2, "fl");
        set_done(5, mh);
        tick;
        done_wen = '0;
        wait_vld(ok);
        oh = mh;
        flush_req = 1;
        retire_ack = 1;
        alloc_req = 1;
        #1;
        total++;
        if (!ok || alloc_gnt !== 1'b0) begin
            bad++;
            $display("FAIL flush_gnt v=%0b gnt=%0b exp v=1 gnt=0", retire_valid, alloc_gnt);
        end
        tick;
        flush_req = 0;
        retire_ack = 0;
        total++;
        if ({retire_valid, read_step, alloc_gnt, count, empty} !== {3'b000, 6'd0, 1'b1}) begin
            bad++;
            $display("FAIL flush_state v=%0b rs=%0b gnt=%0b c=%0d e=%0b exp 0 0 0 0 1",
                     retire_valid, read_step, alloc_gnt, count, empty);
        end
        tick;
        total++;
        if (alloc_gnt !== 1'b1 || writeInit_addr !== oh) begin
            bad++;
            $display("FAIL flush_realloc gnt=%0b wa=%0d exp gnt=1 wa=%0d", alloc_gnt, writeInit_addr, oh);
        end
        tick;
        alloc_req = 0;
        exp_q.delete();
        flush_req = 1;
        tick;
        flush_req = 0;
        tick;
        mt = mh;
    endtask

    task automatic test_wrap;
        do_reset;
        alloc_req = 1;
        for (int k = 0; k < 47; k++) begin
            if (k > 0) set_done(k % 7, 6'(k - 1));
            tick;
            done_wen = '0;
            exp_q.push_back(mt);
            mt = inc(mt);
        end
        alloc_req = 0;
        set_done(6, 6'd46);
        tick;
        done_wen = '0;
        drain(47);
        total++;
        if (empty !== 1'b1 || retire_addr !== 6'd47) begin
            bad++;
            $display("FAIL wrap_head e=%0b head=%0d exp e=1 head=47", empty, retire_addr);
        end
        alloc_n(2, "wrap");
        set_done(3, 6'd5);
        set_done(1, 6'd0);
        tick;
        done_wen = '0;
        tick;
        tick;
        total++;
        if (retire_valid !== 1'b0 || count !== 6'd2) begin
            bad++;
            $display("FAIL wrap_wait v=%0b c=%0d exp v=0 c=2", retire_valid, count);
        end
        set_done(2, 6'd47);
        tick;
        done_wen = '0;
        drain(2);
        total++;
        if (empty !== 1'b1 || retire_valid !== 1'b0) begin
            bad++;
            $display("FAIL wrap_end e=%0b v=%0b exp e=1 v=0", empty, retire_valid);
        end
    endtask

    initial begin
        test_reset;
        test_in_order;
        test_full;
        test_flush;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
